register_file: RTL and testbench



---
 rtl/riscv_pkg.sv | 16 +
 rtl/register_file_read_port.sv | 38 +++
 rtl/register_file.sv | 73 +++++++
 tb/tb_register_file.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Constants shared by decode, writeback and the integer register file.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned ADDR_W    = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // Read-port output select: stored entry or same-cycle writeback value.
    typedef enum logic {
        SEL_STORED = 1'b0,
        SEL_BYPASS = 1'b1
    } rd_sel_e;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: x0 forcing, write-through bypass and final select.
module register_file_read_port
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = riscv_pkg::XLEN,
    parameter int unsigned REG_COUNT = riscv_pkg::REG_COUNT,
    parameter int unsigned ADDR_W    = riscv_pkg::ADDR_W
) (
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [REG_COUNT-1:0][XLEN-1:0]    regs,
    input  logic                              write_en,
    input  logic [ADDR_W-1:0]                 write_addr,
    input  logic [XLEN-1:0]                   write_data,
    output logic [XLEN-1:0]                   data
);

    rd_sel_e           sel;
    logic [XLEN-1:0]   stored;

    always_comb begin
        sel    = SEL_STORED;
        stored = regs[addr];
        if (addr == REG_ZERO) begin
            stored = '0;
        end
        if (write_en && (addr != REG_ZERO) && (write_addr == addr)) begin
            sel = SEL_BYPASS;
        end

        // Reset masks the bypass path too, since writes are ignored while it is high.
        data = '0;
        if (!reset) begin
            data = (sel == SEL_BYPASS) ? write_data : stored;
        end
    end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: x1..x31 storage, x0 hardwired to zero,
// two combinational read ports with write-through bypass.
module register_file
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = riscv_pkg::XLEN,
    parameter int unsigned REG_COUNT = riscv_pkg::REG_COUNT,
    parameter int unsigned ADDR_W    = riscv_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  read_addr1,
    input  logic [ADDR_W-1:0]  read_addr2,
    output logic [XLEN-1:0]    read_data1,
    output logic [XLEN-1:0]    read_data2,
    input  logic               write_en,
    input  logic [ADDR_W-1:0]  write_addr,
    input  logic [XLEN-1:0]    write_data
);

    logic [REG_COUNT-1:1][XLEN-1:0] regs_q;
    logic [REG_COUNT-1:1][XLEN-1:0] regs_d;
    logic [REG_COUNT-1:0][XLEN-1:0] regs_view;

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < REG_COUNT; i++) begin
            if (write_en && (write_addr != REG_ZERO) && (write_addr == ADDR_W'(i))) begin
                regs_d[i] = write_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Entry 0 has no storage; the read ports see a constant zero slot there.
    assign regs_view = {regs_q, {XLEN{1'b0}}};

    register_file_read_port #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_read_port1 (
        .reset      (reset),
        .addr       (read_addr1),
        .regs       (regs_view),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .data       (read_data1)
    );

    register_file_read_port #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_read_port2 (
        .reset      (reset),
        .addr       (read_addr2),
        .regs       (regs_view),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .data       (read_data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array reference model.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    logic [31:0] model [32];

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view: x0 is zero, a live write to the addressed register shows through.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (write_en && write_addr == a) return write_data;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        @(posedge clk);
        if (a != 5'd0) model[a] = d;
        #1;
        write_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        read_addr1 = 5'd9;
        read_addr2 = 5'd0;
        write_en = 1'b0;
        write_addr = 5'd0;
        write_data = 32'h0;
        clear_model();
        #2;
        total_cnt++;
        if (read_data1 !== 32'h0) $display("FAIL reset_hold rd1 got %h exp %h", read_data1, 32'h0);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            read_addr1 = a[4:0];
            read_addr2 = 5'(31 - a);
            #1;
            total_cnt++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0)
                $display("FAIL reset_read addr %0d got %h/%h exp 0/0", a, read_data1, read_data2);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        read_addr1 = 5'd5;
        read_addr2 = 5'd6;
        #1;
        total_cnt++;
        if (read_data1 !== 32'hDEADBEEF) $display("FAIL write_read rd1 got %h exp %h", read_data1, 32'hDEADBEEF);
        else pass_cnt++;
        total_cnt++;
        if (read_data2 !== 32'h0) $display("FAIL write_read rd2 got %h exp %h", read_data2, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = 5'd0;
        write_data = 32'hFFFFFFFF;
        read_addr1 = 5'd0;
        read_addr2 = 5'd5;
        #1;
        total_cnt++;
        if (read_data1 !== 32'h0) $display("FAIL x0_same_cycle rd1 got %h exp %h", read_data1, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (read_data2 !== 32'hDEADBEEF) $display("FAIL x0_no_alias rd2 got %h exp %h", read_data2, 32'hDEADBEEF);
        else pass_cnt++;
        @(negedge clk);
        write_en = 1'b0;
        #1;
        total_cnt++;
        if (read_data1 !== 32'h0) $display("FAIL x0_after_edge rd1 got %h exp %h", read_data1, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h11111111);
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = 5'd7;
        write_data = 32'h22222222;
        read_addr1 = 5'd7;
        read_addr2 = 5'd7;
        #1;
        total_cnt++;
        if (read_data1 !== 32'h22222222 || read_data2 !== 32'h22222222)
            $display("FAIL bypass_before got %h/%h exp %h", read_data1, read_data2, 32'h22222222);
        else pass_cnt++;
        @(posedge clk);
        model[7] = 32'h22222222;
        #1;
        write_en = 1'b0;
        #1;
        total_cnt++;
        if (read_data1 !== 32'h22222222 || read_data2 !== 32'h22222222)
            $display("FAIL bypass_after got %h/%h exp %h", read_data1, read_data2, 32'h22222222);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 32; i++) do_write(i[4:0], 32'h100 + i);
        @(negedge clk);
        read_addr1 = 5'd1;
        read_addr2 = 5'd31;
        #1;
        total_cnt++;
        if (read_data1 !== 32'h101 || read_data2 !== 32'h11F)
            $display("FAIL fill_check got %h/%h exp %h/%h", read_data1, read_data2, 32'h101, 32'h11F);
        else pass_cnt++;
        #1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0)
            $display("FAIL async_reset got %h/%h exp 0/0", read_data1, read_data2);
        else pass_cnt++;
        clear_model();
        // A write attempted during reset must not land.
        write_en   = 1'b1;
        write_addr = 5'd3;
        write_data = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        write_en = 1'b0;
        reset    = 1'b0;
        for (int a = 1; a < 32; a++) begin
            read_addr1 = a[4:0];
            read_addr2 = 5'(32 - a);
            #1;
            total_cnt++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0)
                $display("FAIL post_reset addr %0d got %h/%h exp 0/0", a, read_data1, read_data2);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            write_en   = ($urandom_range(0, 3) != 0);
            write_addr = 5'($urandom_range(0, 31));
            write_data = $urandom;
            // Bias reads toward the write target to exercise bypass frequently.
            read_addr1 = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            read_addr2 = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            #1;
            e1 = ref_read(read_addr1);
            e2 = ref_read(read_addr2);
            total_cnt++;
            if (read_data1 !== e1) $display("FAIL random rd1 cycle %0d addr %0d got %h exp %h", c, read_addr1, read_data1, e1);
            else pass_cnt++;
            total_cnt++;
            if (read_data2 !== e2) $display("FAIL random rd2 cycle %0d addr %0d got %h exp %h", c, read_addr2, read_data2, e2);
            else pass_cnt++;
            @(posedge clk);
            if (write_en && write_addr != 5'd0) model[write_addr] = write_data;
        end
        @(negedge clk);
        write_en = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
